// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Register window (word offsets from BASE_ADDR, address bits [1:0] ignored):
//   +0 DATA   : write pushes wdata[7:0] into the TX FIFO, reads as 0
//   +4 STATUS : [0] full, [1] empty, [2] frame in progress, [3] sticky overflow
//               (write 1 to clear), [11:8] FIFO level
//   +8 DIV    : [15:0] clocks per bit, a written 0 is stored as 1
// Reads are purely combinational so the core sees zero-wait-state loads.

module uart_tx_mmio #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 'h0000_1000,
  parameter int unsigned           CLK_DIV    = 434,
  parameter int unsigned           FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic                  bus_wr_en_i,
  input  logic                  bus_rd_en_i,
  output logic                  bus_sel_o,
  output logic [DATA_WIDTH-1:0] bus_rdata_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] addr_off;
  logic [1:0]            reg_idx;
  logic                  wr_data;
  logic                  wr_status;
  logic                  wr_div;
  logic                  unused_bits;

  // Subtracting the base makes addresses below the window wrap to a huge
  // offset, so one upper-bits-zero test covers both ends of the window.
  assign addr_off  = bus_addr_i - BASE_ADDR;
  assign reg_idx   = addr_off[3:2];
  assign bus_sel_o = (addr_off[DATA_WIDTH-1:4] == '0) && (reg_idx != 2'd3);

  assign wr_data   = bus_sel_o && bus_wr_en_i && (reg_idx == 2'd0);
  assign wr_status = bus_sel_o && bus_wr_en_i && (reg_idx == 2'd1);
  assign wr_div    = bus_sel_o && bus_wr_en_i && (reg_idx == 2'd2);

  assign unused_bits = ^{addr_off[1:0], bus_wdata_i[DATA_WIDTH-1:16]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_acc;
  logic          fifo_pop;

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  // Fullness is judged before the edge: a pop on the same edge does not
  // make room for the incoming byte.
  assign push_acc   = wr_data && !fifo_full;

  // FIFO storage; contents need no reset because the level gates every read
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      fifo_mem[wr_ptr] <= bus_wdata_i[7:0];
    end
  end

  // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, fifo_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic        overflow;
  logic [15:0] div_q;

  // Sticky overflow flag and the clocks-per-bit divider
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow <= 1'b0;
      div_q    <= 16'(CLK_DIV);
    end else begin
      if (wr_data && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_status && bus_wdata_i[3]) begin
        overflow <= 1'b0;
      end
      if (wr_div) begin
        div_q <= (bus_wdata_i[15:0] == 16'd0) ? 16'd1 : bus_wdata_i[15:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [15:0] bit_cnt;
  logic [15:0] frame_div;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        cnt_zero;
  logic        fsm_active;

  assign cnt_zero = (bit_cnt == 16'd0);

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; also decides when a byte leaves the FIFO
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_zero && (bit_idx == 3'd7)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: line level and frame-in-progress flag
  always_comb begin
    tx_o       = 1'b1;
    fsm_active = 1'b1;
    case (state_q)
      ST_IDLE:  fsm_active = 1'b0;
      ST_START: tx_o       = 1'b0;
      ST_DATA:  tx_o       = shift_q[0];
      default:  tx_o       = 1'b1;
    endcase
  end

  assign busy_o = fsm_active || !fifo_empty;

  // Frame datapath: a pop latches the byte and the divider for the whole
  // frame, so DIV writes mid-frame only affect the next frame.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bit_cnt   <= 16'd0;
      frame_div <= 16'd1;
      bit_idx   <= 3'd0;
      shift_q   <= 8'd0;
    end else if (fifo_pop) begin
      shift_q   <= fifo_mem[rd_ptr];
      frame_div <= div_q;
      bit_cnt   <= div_q - 16'd1;
    end else if (state_q != ST_IDLE) begin
      if (!cnt_zero) begin
        bit_cnt <= bit_cnt - 16'd1;
      end else begin
        bit_cnt <= frame_div - 16'd1;
        if (state_q == ST_START) begin
          bit_idx <= 3'd0;
        end
        if (state_q == ST_DATA) begin
          bit_idx <= bit_idx + 3'd1;
          shift_q <= {1'b0, shift_q[7:1]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------

  // Zero-wait-state load data; DATA and unselected accesses read as 0
  always_comb begin
    bus_rdata_o = '0;
    if (bus_sel_o && bus_rd_en_i) begin
      case (reg_idx)
        2'd1: begin
          bus_rdata_o[0]    = fifo_full;
          bus_rdata_o[1]    = fifo_empty;
          bus_rdata_o[2]    = fsm_active;
          bus_rdata_o[3]    = overflow;
          bus_rdata_o[11:8] = 4'(level);
        end
        2'd2:    bus_rdata_o[15:0] = div_q;
        default: bus_rdata_o = '0;
      endcase
    end
  end

endmodule
